// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush and load-use
// stall arbitration, with wait watchdog and stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        exe_DM_read,
  input  logic        exe_wen,
  input  logic [4:0]  exe_waddr,
  input  logic        exe_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        clr_cnt,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idexe_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idexe_flush,
  output logic        memwb_flush,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e             state_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [WAIT_W-1:0]  wait_inc;
  logic               mem_timeout_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   flush_cnt_q;

  logic freeze_c;
  logic branch_c;
  logic hazard_c;
  logic load_stall_c;
  logic rs1_match_c;
  logic rs2_match_c;

  // Hazard conditions, resolved in priority order freeze > branch > load-use
  assign rs1_match_c  = id_rs1_used && (id_rs1_addr == exe_waddr);
  assign rs2_match_c  = id_rs2_used && (id_rs2_addr == exe_waddr);
  assign hazard_c     = exe_DM_read && exe_wen && (exe_waddr != 5'd0) &&
                        (rs1_match_c || rs2_match_c);
  assign freeze_c     = !rst && mem_req && !mem_ready;
  assign branch_c     = !rst && !freeze_c && exe_branch_taken;
  assign load_stall_c = !rst && !freeze_c && !exe_branch_taken && hazard_c;

  // Saturating next value of the memory-wait counter
  assign wait_inc = (wait_q == {WAIT_W{1'b1}}) ? wait_q : wait_q + WAIT_W'(1);

  // Mealy stall/flush decode; everything forced low while rst is high
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idexe_stall = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idexe_flush = 1'b0;
    memwb_flush = 1'b0;
    if (freeze_c) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idexe_stall = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (branch_c) begin
      ifid_flush  = 1'b1;
      idexe_flush = 1'b1;
    end else if (load_stall_c) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idexe_flush = 1'b1;
    end
  end

  // RUN/MEM_WAIT state, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (freeze_c) begin
            state_q <= MEM_WAIT;
            wait_q  <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q <= RUN;
          end else if (freeze_c) begin
            wait_q <= wait_inc;
            if (32'(wait_inc) >= WAIT_LIMIT) begin
              mem_timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Stall-cycle counter: saturating, clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (clr_cnt) begin
      stall_cnt_q <= '0;
    end else if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Branch-flush event counter: saturating, clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else if (clr_cnt) begin
      flush_cnt_q <= '0;
    end else if (branch_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned WAIT_LIMIT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, exe_waddr;
  logic        id_rs1_used, id_rs2_used, exe_DM_read, exe_wen;
  logic        exe_branch_taken, mem_req, mem_ready, clr_cnt;
  logic        pc_stall, ifid_stall, idexe_stall, exmem_stall;
  logic        ifid_flush, idexe_flush, memwb_flush, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_stall_cnt, m_flush_cnt, m_waited;
  bit m_timeout, m_waiting;

  pipe_hazard_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .exe_DM_read(exe_DM_read), .exe_wen(exe_wen), .exe_waddr(exe_waddr),
    .exe_branch_taken(exe_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idexe_stall(idexe_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush),
    .idexe_flush(idexe_flush), .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control outputs derived from the priority rules
  task automatic expect_ctrl(output bit [6:0] e);
    bit frz, br, haz;
    frz = mem_req && !mem_ready;
    haz = exe_DM_read && exe_wen && exe_waddr != 0 &&
          ((id_rs1_used && id_rs1_addr == exe_waddr) ||
           (id_rs2_used && id_rs2_addr == exe_waddr));
    br  = !frz && exe_branch_taken;
    // {pc, ifid_s, idexe_s, exmem_s, ifid_f, idexe_f, memwb_f}
    if (rst)      e = 7'b0000000;
    else if (frz) e = 7'b1111001;
    else if (br)  e = 7'b0000110;
    else if (haz) e = 7'b1100010;
    else          e = 7'b0000000;
  endtask

  task automatic check_all(input string tag);
    bit [6:0] e;
    expect_ctrl(e);
    chk({tag, ".pc_stall"},    16'(pc_stall),    16'(e[6]));
    chk({tag, ".ifid_stall"},  16'(ifid_stall),  16'(e[5]));
    chk({tag, ".idexe_stall"}, 16'(idexe_stall), 16'(e[4]));
    chk({tag, ".exmem_stall"}, 16'(exmem_stall), 16'(e[3]));
    chk({tag, ".ifid_flush"},  16'(ifid_flush),  16'(e[2]));
    chk({tag, ".idexe_flush"}, 16'(idexe_flush), 16'(e[1]));
    chk({tag, ".memwb_flush"}, 16'(memwb_flush), 16'(e[0]));
    chk({tag, ".mem_timeout"}, 16'(mem_timeout), 16'(m_timeout));
    chk({tag, ".stall_cnt"},   stall_cnt,        16'(m_stall_cnt));
    chk({tag, ".flush_cnt"},   flush_cnt,        16'(m_flush_cnt));
  endtask

  task automatic model_reset();
    m_stall_cnt = 0; m_flush_cnt = 0; m_waited = 0;
    m_timeout = 1'b0; m_waiting = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs of that cycle
  task automatic model_edge();
    bit [6:0] e;
    bit frz;
    if (rst) begin
      model_reset();
      return;
    end
    expect_ctrl(e);
    frz = mem_req && !mem_ready;
    if (clr_cnt) m_stall_cnt = 0;
    else if (e[6] && m_stall_cnt < 65535) m_stall_cnt++;
    if (clr_cnt) m_flush_cnt = 0;
    else if (e[2] && m_flush_cnt < 65535) m_flush_cnt++;
    if (!m_waiting) begin
      if (frz) begin m_waiting = 1'b1; m_waited = 0; end
    end else if (mem_ready) begin
      m_waiting = 1'b0;
    end else if (frz) begin
      if (m_waited < 255) m_waited++;
      if (m_waited >= WAIT_LIMIT) m_timeout = 1'b1;
    end
  endtask

  // Check the current cycle, then clock it; returns at the next negedge
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    exe_DM_read = 0; exe_wen = 0; exe_waddr = 0; exe_branch_taken = 0;
    mem_req = 0; mem_ready = 0; clr_cnt = 0;
  endtask

  task automatic random_inputs();
    id_rs1_addr = 5'($urandom_range(0, 3));
    id_rs2_addr = 5'($urandom_range(0, 3));
    exe_waddr   = 5'($urandom_range(0, 3));
    id_rs1_used = 1'($urandom);
    id_rs2_used = 1'($urandom);
    exe_DM_read = 1'($urandom);
    exe_wen     = ($urandom_range(0, 3) != 0);
    exe_branch_taken = ($urandom_range(0, 4) == 0);
    mem_req     = ($urandom_range(0, 2) == 0);
    mem_ready   = 1'($urandom);
    clr_cnt     = ($urandom_range(0, 30) == 0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    // Reset holds everything low whatever the inputs do
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      random_inputs();
      mem_req = 1'b1; mem_ready = 1'b0; exe_branch_taken = 1'b1;
      step("reset");
    end
    idle_inputs();
    rst = 1'b0;
    step("idle");

    // Load x5 in EXE, rs2=5 used in ID: one bubble
    exe_DM_read = 1; exe_wen = 1; exe_waddr = 5; id_rs2_addr = 5; id_rs2_used = 1;
    #1;
    chk("loaduse.pc_stall", 16'(pc_stall), 16'd1);
    step("loaduse");
    idle_inputs();
    chk("loaduse.stall_cnt", stall_cnt, 16'd1);
    step("after_loaduse");

    // Destination x0 never causes a hazard
    exe_DM_read = 1; exe_wen = 1; exe_waddr = 0; id_rs1_addr = 0; id_rs1_used = 1;
    step("x0_load");
    idle_inputs();

    // Branch beats a simultaneous load-use hazard
    exe_DM_read = 1; exe_wen = 1; exe_waddr = 7; id_rs1_addr = 7; id_rs1_used = 1;
    exe_branch_taken = 1;
    #1;
    chk("branch.pc_stall", 16'(pc_stall), 16'd0);
    chk("branch.ifid_flush", 16'(ifid_flush), 16'd1);
    step("branch_vs_hazard");
    idle_inputs();
    chk("branch.flush_cnt", flush_cnt, 16'd1);
    step("after_branch");

    // Three frozen cycles then ready
    clr_cnt = 1;
    step("clr");
    idle_inputs();
    chk("clr.stall_cnt", stall_cnt, 16'd0);
    for (int i = 0; i < 3; i++) begin
      mem_req = 1; mem_ready = 0; exe_branch_taken = 1;
      step("freeze3");
    end
    mem_ready = 1;
    step("ready");
    idle_inputs();
    chk("freeze3.stall_cnt", stall_cnt, 16'd3);
    step("after_ready");

    // Clear collides with an increment: clear wins
    exe_DM_read = 1; exe_wen = 1; exe_waddr = 3; id_rs1_addr = 3; id_rs1_used = 1;
    clr_cnt = 1;
    step("clr_vs_inc");
    idle_inputs();
    chk("clr_vs_inc.stall_cnt", stall_cnt, 16'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      random_inputs();
      step("rand");
    end
    idle_inputs();
    mem_ready = 1;
    step("drain");
    idle_inputs();

    // Long wait trips the watchdog; flag survives the ready cycle
    for (int i = 0; i < 300; i++) begin
      mem_req = 1; mem_ready = 0;
      if (i == 255) chk("timeout.before_limit", 16'(mem_timeout), 16'd0);
      step("longwait");
    end
    chk("timeout.set", 16'(mem_timeout), 16'd1);
    mem_ready = 1;
    step("longwait_ready");
    idle_inputs();
    step("post_timeout");
    chk("timeout.sticky", 16'(mem_timeout), 16'd1);

    // Asynchronous reset in the middle of a wait
    for (int i = 0; i < 4; i++) begin
      mem_req = 1; mem_ready = 0;
      step("prewait");
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.stall_cnt", stall_cnt, 16'd0);
    chk("async_rst.timeout", 16'(mem_timeout), 16'd0);
    @(negedge clk);
    step("rst_held");
    rst = 1'b0;
    idle_inputs();
    step("post_rst_idle");
    // Fresh evaluation after release: a single freeze cycle then ready
    mem_req = 1; mem_ready = 0;
    step("post_rst_freeze");
    mem_ready = 1;
    step("post_rst_ready");
    idle_inputs();
    for (int i = 0; i < 50; i++) begin
      random_inputs();
      step("rand_tail");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1_addr  in  5  ID-stage source register 1 index.
- id_rs2_addr  in  5  ID-stage source register 2 index.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- exe_DM_read  in  1  EXE-stage instruction is a load.
- exe_wen  in  1  EXE-stage instruction writes a register.
- exe_waddr  in  5  EXE-stage destination index.
- exe_branch_taken  in  1  EXE resolved a taken branch/jump.
- mem_req  in  1  MEM stage has a data-memory access in flight.
- mem_ready  in  1  data memory completes the access this cycle.
- clr_cnt  in  1  synchronous clear of performance counters.
- pc_stall, ifid_stall, idexe_stall, exmem_stall  out  1 each  hold the PC / corresponding pipeline register.
- ifid_flush, idexe_flush, memwb_flush  out  1 each  load bubble (NOP, DM_read/DM_write disabled) into the register.
- mem_timeout  out  1  sticky: memory wait exceeded limit.
- stall_cnt  out  16  cycles with pc_stall=1.
- flush_cnt  out  16  branch flush events.
REQ-002 Parameter WAIT_LIMIT, default 255, memory-wait cycles before mem_timeout sets.

Function
REQ-003 FSM states SHALL be RUN and MEM_WAIT, held in one registered state variable; control outputs are Mealy (state + current inputs).
REQ-004 freeze = mem_req & ~mem_ready (either state); freeze SHALL assert pc_stall, ifid_stall, idexe_stall, exmem_stall, memwb_flush and force all other flushes to 0.
REQ-005 RUN -> MEM_WAIT when freeze=1; MEM_WAIT -> RUN on the cycle mem_ready=1 (no freeze that cycle); otherwise hold state.
REQ-006 Branch flush: when freeze=0 and exe_branch_taken=1, SHALL assert ifid_flush and idexe_flush for exactly that cycle; all stalls 0.
REQ-007 Load-use hazard = exe_DM_read & exe_wen & (exe_waddr!=0) & ((id_rs1_used & id_rs1_addr==exe_waddr) | (id_rs2_used & id_rs2_addr==exe_waddr)).
REQ-008 When freeze=0, exe_branch_taken=0 and hazard=1: assert pc_stall, ifid_stall, idexe_flush; EXE/MEM and MEM/WB advance; one bubble per hazard instance.
REQ-009 Priority SHALL be freeze > branch flush > load-use stall; a branch arriving during freeze is applied on the first unfrozen cycle (inputs remain valid because EXE is held).
REQ-010 No condition active: all stall/flush outputs 0.
REQ-011 Wait counter (8-bit) SHALL clear on entering MEM_WAIT, increment each MEM_WAIT cycle with freeze=1, saturate at 255; reaching WAIT_LIMIT sets mem_timeout, which stays 1 until rst; pipeline keeps waiting.
REQ-012 stall_cnt SHALL increment on each cycle pc_stall=1; flush_cnt increments on each REQ-006 cycle; both saturate at 0xFFFF.
REQ-013 clr_cnt=1 SHALL zero stall_cnt and flush_cnt next edge, overriding same-cycle increment; does not affect mem_timeout or FSM.

Reset
REQ-014 While rst=1: state RUN, wait counter 0, mem_timeout 0, stall_cnt 0, flush_cnt 0, all stall/flush outputs 0, regardless of inputs.
REQ-015 rst asserted mid-MEM_WAIT SHALL abort the wait immediately; after release, FSM in RUN evaluates inputs afresh.

Verification
REQ-016 Load x5 in EXE (exe_DM_read=1, exe_wen=1, exe_waddr=5), ID rs2=5 used -> one cycle pc_stall=ifid_stall=idexe_flush=1, stall_cnt=1.
REQ-017 Same with exe_waddr=0 and rs1=0 used -> no stall, all outputs 0.
REQ-018 exe_branch_taken=1 with simultaneous load-use hazard -> ifid_flush=idexe_flush=1, pc_stall=0, flush_cnt=1.
REQ-019 mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles all stalls+memwb_flush=1, state MEM_WAIT, RUN after ready cycle, stall_cnt=3.
REQ-020 mem_req=1, mem_ready=0 for 300 cycles -> mem_timeout=1 from wait-count 255 onward, remains 1 after mem_ready; cleared only by rst.
REQ-021 rst pulse during MEM_WAIT with counters nonzero -> all outputs 0 asynchronously, state RUN, counters 0.
